// File: rtl/out_bram_wconv_pkg.sv
// Shared constants and helpers for the width-converting output BRAM.
package out_bram_wconv_pkg;

  // Default memory geometry in narrow (read-width) entries.
  localparam int BRAM_DEPTH_IN      = 2048;
  localparam int LOG2_BRAM_DEPTH_IN = 11;

  // Address width for n locations, never below one bit so that single-row
  // or single-bank configurations still get a legal vector.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/out_bram_bank.sv
// One interleaved storage bank: simple dual-port, read-first block RAM.
module out_bram_bank
  import out_bram_wconv_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ROWS   = 1024,
  localparam int ROW_W = clog2_min1(ROWS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ROW_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ROW_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  (* ram_style = "block" *) logic [DATA_W-1:0] mem [ROWS];

  // Write and registered read share one process so a collision returns the
  // old contents (read-first); storage and output register are not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/out_bram_wconv.sv
// Wide-write / narrow-read output buffer with single and burst reads.
module out_bram_wconv
  import out_bram_wconv_pkg::*;
#(
  parameter int ADDR_WIDTH     = LOG2_BRAM_DEPTH_IN,
  parameter int OUT_DATA_WIDTH = 128,
  parameter int RATIO          = 2,
  parameter int DEPTH          = BRAM_DEPTH_IN,
  localparam int IN_DATA_WIDTH = OUT_DATA_WIDTH * RATIO
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [IN_DATA_WIDTH-1:0]  wr_data,
  input  logic [RATIO-1:0]          wr_lane_en,
  input  logic                      re,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  input  logic                      burst_start,
  input  logic [ADDR_WIDTH-1:0]     burst_addr,
  input  logic [ADDR_WIDTH:0]       burst_len,
  output logic                      busy,
  output logic [OUT_DATA_WIDTH-1:0] rd_data,
  output logic                      rd_vld,
  output logic                      rd_last,
  output logic                      burst_done
);

  localparam int LR    = $clog2(RATIO);
  localparam int ROWS  = DEPTH / RATIO;
  localparam int ROW_W = clog2_min1(ROWS);
  localparam int BS_W  = clog2_min1(RATIO);
  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH + 1)'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     rem_q, rem_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    start_ok;

  logic                    issue;
  logic                    issue_last;
  logic [ADDR_WIDTH-1:0]   issue_addr;
  logic [ROW_W-1:0]        rd_row;
  logic [BS_W-1:0]         rd_sel;

  logic                    vld_p1;
  logic                    last_p1;
  logic [BS_W-1:0]         sel_p1;

  logic                      bank_we    [RATIO];
  logic [ROW_W-1:0]          bank_waddr [RATIO];
  logic [OUT_DATA_WIDTH-1:0] bank_wdata [RATIO];
  logic                      bank_re    [RATIO];
  logic [OUT_DATA_WIDTH-1:0] bank_q     [RATIO];

  // Route each write lane to the bank owning its (wrapped) narrow address;
  // RATIO consecutive addresses always land in RATIO distinct banks.
  always_comb begin
    logic [ADDR_WIDTH-1:0] lane_addr;
    int                    bidx;
    for (int b = 0; b < RATIO; b++) begin
      bank_we[b]    = 1'b0;
      bank_waddr[b] = '0;
      bank_wdata[b] = '0;
    end
    for (int k = 0; k < RATIO; k++) begin
      lane_addr            = wr_addr + ADDR_WIDTH'(k);
      bidx                 = int'(lane_addr) & (RATIO - 1);
      bank_we[bidx]        = we & wr_lane_en[k];
      bank_waddr[bidx]     = ROW_W'(lane_addr >> LR);
      bank_wdata[bidx]     = wr_data[k*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
    end
  end

  // Next-state logic: one read address per cycle from a burst or a random
  // read; on the final burst data cycle a new burst may start immediately.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    addr_d     = addr_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_addr = rd_addr;
    start_ok   = burst_start && (burst_len != '0);
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          issue      = 1'b1;
          issue_addr = burst_addr;
          issue_last = (burst_len == LEN_ONE);
          addr_d     = burst_addr + ADDR_WIDTH'(1);
          rem_d      = burst_len - LEN_ONE;
          state_d    = ST_BURST;
        end else if (re) begin
          issue = 1'b1;
        end
      end
      ST_BURST: begin
        if (rem_q != '0) begin
          issue      = 1'b1;
          issue_addr = addr_q;
          issue_last = (rem_q == LEN_ONE);
          addr_d     = addr_q + ADDR_WIDTH'(1);
          rem_d      = rem_q - LEN_ONE;
        end else if (start_ok) begin
          issue      = 1'b1;
          issue_addr = burst_addr;
          issue_last = (burst_len == LEN_ONE);
          addr_d     = burst_addr + ADDR_WIDTH'(1);
          rem_d      = burst_len - LEN_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and burst address/count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
    end
  end

  assign rd_row = ROW_W'(issue_addr >> LR);
  assign rd_sel = BS_W'(int'(issue_addr) & (RATIO - 1));

  // Only the bank holding the requested entry is read.
  always_comb begin
    for (int b = 0; b < RATIO; b++) begin
      bank_re[b] = issue && (int'(rd_sel) == b);
    end
  end

  for (genvar b = 0; b < RATIO; b++) begin : g_bank
    out_bram_bank #(
      .DATA_W (OUT_DATA_WIDTH),
      .ROWS   (ROWS)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[b]),
      .waddr (bank_waddr[b]),
      .wdata (bank_wdata[b]),
      .re    (bank_re[b]),
      .raddr (rd_row),
      .rdata (bank_q[b])
    );
  end

  // ---- stage p0 -> p1: read issue to BRAM output ----
  // Valid and last flags follow the BRAM one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= issue;
      last_p1 <= issue_last;
    end
  end

  // Bank select travels with the read so the output mux picks the right bank.
  always_ff @(posedge clk) begin
    if (issue) sel_p1 <= rd_sel;
  end

  assign rd_data    = vld_p1 ? bank_q[sel_p1] : '0;
  assign rd_vld     = vld_p1;
  assign rd_last    = last_p1;
  assign burst_done = last_p1;
  assign busy       = (state_q == ST_BURST);

endmodule

// File: tb/tb_out_bram_wconv.sv
// Self-checking bench for out_bram_wconv against a queue/array reference.
module tb_out_bram_wconv;

  localparam int AW = 11;
  localparam int DW = 128;
  localparam int R  = 2;
  localparam int D  = 2048;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            we;
  logic [AW-1:0]   wr_addr;
  logic [DW*R-1:0] wr_data;
  logic [R-1:0]    wr_lane_en;
  logic            re;
  logic [AW-1:0]   rd_addr;
  logic            burst_start;
  logic [AW-1:0]   burst_addr;
  logic [AW:0]     burst_len;
  logic            busy;
  logic [DW-1:0]   rd_data;
  logic            rd_vld;
  logic            rd_last;
  logic            burst_done;

  int vectors    = 0;
  int miscompares = 0;

  // Reference state: memory image, addresses of the burst still to be read,
  // and whether the previous cycle issued a burst read (DUT reports busy).
  logic [DW-1:0]   model [D];
  logic [AW-1:0]   pend [$];
  bit              mbusy = 1'b0;

  out_bram_wconv dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .we          (we),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_lane_en  (wr_lane_en),
    .re          (re),
    .rd_addr     (rd_addr),
    .burst_start (burst_start),
    .burst_addr  (burst_addr),
    .burst_len   (burst_len),
    .busy        (busy),
    .rd_data     (rd_data),
    .rd_vld      (rd_vld),
    .rd_last     (rd_last),
    .burst_done  (burst_done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_vld"},  rd_vld, 0);
    chk({tag, "_last"}, rd_last, 0);
    chk({tag, "_done"}, burst_done, 0);
    chk({tag, "_data"}, rd_data, 0);
  endtask

  task automatic set_idle();
    we = 1'b0; wr_addr = '0; wr_data = '0; wr_lane_en = '0;
    re = 1'b0; rd_addr = '0;
    burst_start = 1'b0; burst_addr = '0; burst_len = '0;
  endtask

  // Apply the current inputs for one clock, predict the outputs from the
  // reference, then compare just after the edge.
  task automatic cycle(input string tag);
    logic [AW-1:0] a = '0;
    bit            iss = 1'b0;
    bit            biss = 1'b0;
    bit            lst = 1'b0;
    logic [DW-1:0] ed;
    if (pend.size() == 0 && burst_start && burst_len != 0) begin
      for (int i = 0; i < int'(burst_len); i++)
        pend.push_back(AW'((int'(burst_addr) + i) % D));
    end
    if (pend.size() != 0) begin
      a = pend.pop_front(); iss = 1'b1; biss = 1'b1; lst = (pend.size() == 0);
    end else if (!mbusy && re) begin
      a = rd_addr; iss = 1'b1;
    end
    ed = iss ? model[a] : '0;
    for (int k = 0; k < R; k++)
      if (we && wr_lane_en[k]) model[AW'((int'(wr_addr) + k) % D)] = wr_data[k*DW +: DW];
    mbusy = biss;
    @(posedge clk); #1;
    chk({tag, "_busy"}, busy, biss);
    chk({tag, "_vld"},  rd_vld, iss);
    chk({tag, "_last"}, rd_last, lst);
    chk({tag, "_done"}, burst_done, lst);
    chk({tag, "_data"}, rd_data, ed);
  endtask

  task automatic do_write(input int addr, input logic [R-1:0] en, input logic [DW*R-1:0] d);
    set_idle(); we = 1'b1; wr_addr = AW'(addr); wr_lane_en = en; wr_data = d;
  endtask

  task automatic do_read(input int addr);
    set_idle(); re = 1'b1; rd_addr = AW'(addr);
  endtask

  task automatic do_burst(input int addr, input int len);
    set_idle(); burst_start = 1'b1; burst_addr = AW'(addr); burst_len = (AW+1)'(len);
  endtask

  initial begin
    logic [DW-1:0] va, vb;
    set_idle();
    rst_n = 1'b0;
    #1;
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill the whole memory so every later read has a known reference.
    for (int i = 0; i < D / R; i++) begin
      do_write(i * R, 2'b11, {rnd128(), rnd128()});
      cycle("init");
    end

    // Wide write then two narrow reads of its lanes.
    va = rnd128(); vb = rnd128();
    do_write(4, 2'b11, {vb, va}); cycle("wr4");
    do_read(4); cycle("rd4");
    chk("lane_a", rd_data, va);
    do_read(5); cycle("rd5");
    chk("lane_b", rd_data, vb);

    // Wrap of the second lane, then a single-lane write.
    do_write(2047, 2'b11, {rnd128(), rnd128()}); cycle("wrwrap");
    do_read(2047); cycle("rdwrap_hi");
    do_read(0); cycle("rdwrap_lo");
    do_write(2047, 2'b01, {rnd128(), rnd128()}); cycle("wrlane0");
    do_read(0); cycle("rdlane_untouched");
    do_read(2047); cycle("rdlane_new");

    // Burst across the top of the address space.
    do_burst(2046, 4); cycle("bwrap0");
    set_idle();
    for (int i = 0; i < 5; i++) cycle("bwrap");

    // Ignored starts while busy and zero length, then back-to-back on done.
    do_burst(10, 3); cycle("b2b_s");
    do_burst(300, 5); re = 1'b1; cycle("b2b_busy");
    do_burst(400, 0); cycle("b2b_len0");
    do_burst(20, 2); cycle("b2b_done");
    set_idle();
    for (int i = 0; i < 4; i++) cycle("b2b_tail");
    do_burst(30, 0); cycle("idle_len0");
    set_idle(); cycle("idle_len0_t");
    do_burst(40, 1); re = 1'b1; rd_addr = AW'(99); cycle("len1_re");
    set_idle(); cycle("len1_t0"); cycle("len1_t1");

    // Read-first collision, then the new value.
    do_write(50, 2'b01, {rnd128(), rnd128()}); re = 1'b1; rd_addr = AW'(50);
    cycle("coll_old");
    do_read(50); cycle("coll_new");

    // Writes during a burst, including to entries the burst is about to read.
    do_burst(60, 6); cycle("bw_s");
    do_write(62, 2'b11, {rnd128(), rnd128()}); cycle("bw_w0");
    do_write(63, 2'b10, {rnd128(), rnd128()}); cycle("bw_w1");
    set_idle();
    for (int i = 0; i < 6; i++) cycle("bw_t");

    // Asynchronous reset in the middle of a burst.
    do_burst(100, 8); cycle("rb_s");
    set_idle(); cycle("rb_1"); cycle("rb_2");
    #2 rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    pend.delete(); mbusy = 1'b0;
    @(posedge clk); #1;
    chk_zero("rst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle("rst_after");
    do_read(4); cycle("keep4");
    do_read(0); cycle("keep0");
    do_read(105); cycle("keep105");

    // Randomized traffic with frequent wraps, collisions and burst requests.
    for (int i = 0; i < 500; i++) begin
      we          = 1'($urandom_range(0, 1));
      wr_addr     = ($urandom_range(0, 3) == 0) ? AW'(2046 + $urandom_range(0, 1)) : AW'($urandom);
      wr_lane_en  = R'($urandom);
      wr_data     = {rnd128(), rnd128()};
      re          = 1'($urandom_range(0, 1));
      rd_addr     = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom);
      burst_start = ($urandom_range(0, 4) == 0);
      burst_addr  = ($urandom_range(0, 2) == 0) ? AW'(2044 + $urandom_range(0, 3)) : AW'($urandom);
      burst_len   = (AW+1)'($urandom_range(0, 6));
      cycle("rand");
    end
    set_idle();
    for (int i = 0; i < 10; i++) cycle("drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
